// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display definitions: blank constants, active-low glyph table,
// scan FSM states and a lowest-set-bit helper.
package seg_scan_ctrl_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SCAN_OFF  = 8'hFF;

  // {g,f,e,d,c,b,a}, 0 = segment lit; 0-9 then A,b,C,d,E,F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ON    = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module hex7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan controller with blanking gaps,
// digit masking and frame-synchronous display updates.
//
// state | meaning
// IDLE  | display dark, waiting for a tick with enable and a non-zero mask
// ON    | digit ptr lit for ON_TICKS ticks
// BLANK | all digits off for BLANK_TICKS ticks, then pick the next digit
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIV         = 50000,
  parameter int unsigned ON_TICKS    = 4,
  parameter int unsigned BLANK_TICKS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  digit_mask,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  output logic        wr_ready,
  output logic [7:0]  scan_out,
  output logic [7:0]  seg_out,
  output logic        frame_done
);

  localparam int unsigned DIV_W  = $clog2(DIV);
  localparam int unsigned PH_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
  localparam int unsigned PH_W   = $clog2(PH_MAX) + 1;

  scan_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [31:0]       act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [7:0]        act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic              pend_valid_q, pend_valid_d;
  logic [7:0]        scan_q, scan_d, seg_q, seg_d;
  logic              frame_q, frame_d;
  logic              tick, commit;
  logic [7:0]        above;
  logic [6:0]        glyph;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    ptr_d        = ptr_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    frame_d      = 1'b0;
    commit       = 1'b0;
    above        = 8'h00;
    tick         = (div_q == DIV_W'(DIV - 1));

    if (!enable) begin
      state_d = ST_IDLE;
      div_d   = '0;
      phase_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (|digit_mask) begin
              commit  = 1'b1;
              ptr_d   = lowest_set(digit_mask);
              phase_d = '0;
              state_d = ST_ON;
            end
          end
          ST_ON: begin
            if (phase_q == PH_W'(ON_TICKS - 1)) begin
              phase_d = '0;
              state_d = ST_BLANK;
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
          ST_BLANK: begin
            if (phase_q == PH_W'(BLANK_TICKS - 1)) begin
              phase_d = '0;
              // mask bits strictly above the digit just shown
              above   = digit_mask & ~((8'd2 << ptr_q) - 8'd1);
              if (|above) begin
                ptr_d   = lowest_set(above);
                state_d = ST_ON;
              end else begin
                frame_d = 1'b1;
                commit  = 1'b1;
                if (|digit_mask) begin
                  ptr_d   = lowest_set(digit_mask);
                  state_d = ST_ON;
                end else begin
                  state_d = ST_IDLE;
                end
              end
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (commit && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (wr_valid && !pend_valid_q) begin
      pend_data_d  = wr_data;
      pend_dp_d    = wr_dp;
      pend_valid_d = 1'b1;
    end
  end

  // Decode from next-state values so outputs move on the transition edge.
  hex7seg u_hex7seg (
    .hex_i (act_data_d[{ptr_d, 2'b00} +: 4]),
    .seg_o (glyph)
  );

  always_comb begin
    scan_d = SCAN_OFF;
    seg_d  = SEG_BLANK;
    if (state_d == ST_ON) begin
      scan_d = ~(8'd1 << ptr_d);
      seg_d  = {~act_dp_d[ptr_d], glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_q        <= '0;
      phase_q      <= '0;
      ptr_q        <= 3'd0;
      act_data_q   <= 32'h0;
      act_dp_q     <= 8'h00;
      pend_data_q  <= 32'h0;
      pend_dp_q    <= 8'h00;
      pend_valid_q <= 1'b0;
      scan_q       <= SCAN_OFF;
      seg_q        <= SEG_BLANK;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      ptr_q        <= ptr_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      scan_q       <= scan_d;
      seg_q        <= seg_d;
      frame_q      <= frame_d;
    end
  end

  assign wr_ready   = ~pend_valid_q;
  assign scan_out   = scan_q;
  assign seg_out    = seg_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus randomized stimulus,
// checked every cycle against a tick-budget model of the scan behaviour.
module tb_seg_scan_ctrl;

  localparam int DIV  = 4;
  localparam int ON_T = 2;
  localparam int BL_T = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  digit_mask = 8'h00;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic [7:0]  wr_dp = 8'h00;
  logic        wr_ready, frame_done;
  logic [7:0]  scan_out, seg_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV), .ON_TICKS(ON_T), .BLANK_TICKS(BL_T)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .digit_mask (digit_mask),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_ready   (wr_ready),
    .scan_out   (scan_out),
    .seg_out    (seg_out),
    .frame_done (frame_done)
  );

  // Full active-low segment bytes with the decimal point off.
  logic [7:0] gl [16];
  initial begin
    gl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  end

  // Model: mode 0 dark, 1 digit lit, 2 gap; m_left = ticks left in the mode.
  int          m_mode = 0, m_div = 0, m_left = 0, m_ptr = 0;
  logic [31:0] m_act = 0, m_pend = 0;
  logic [7:0]  m_adp = 0, m_pdp = 0;
  bit          m_pv = 0, m_live = 0;
  logic [7:0]  e_scan = 8'hFF, e_seg = 8'hFF;
  bit          e_fd = 0;

  function automatic int first_from(input int from, input logic [7:0] m);
    for (int i = from; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin : model
    bit fire, tick, commit;
    int nx;
    if (reset) begin
      m_mode = 0; m_div = 0; m_left = 0; m_ptr = 0;
      m_act = 0; m_adp = 0; m_pend = 0; m_pdp = 0; m_pv = 0;
      e_fd = 0; m_live = 1;
    end else begin
      fire = wr_valid && !m_pv;
      commit = 0;
      e_fd = 0;
      if (!enable) begin
        m_mode = 0;
        m_div = 0;
      end else begin
        tick = (m_div == DIV - 1);
        m_div = tick ? 0 : m_div + 1;
        if (tick) begin
          if (m_mode == 0) begin
            if (digit_mask != 0) begin
              commit = 1; m_ptr = first_from(0, digit_mask); m_mode = 1; m_left = ON_T;
            end
          end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin m_mode = 2; m_left = BL_T; end
          end else begin
            m_left--;
            if (m_left == 0) begin
              nx = first_from(m_ptr + 1, digit_mask);
              if (nx >= 0) begin
                m_ptr = nx; m_mode = 1; m_left = ON_T;
              end else begin
                e_fd = 1; commit = 1;
                nx = first_from(0, digit_mask);
                if (nx < 0) m_mode = 0;
                else begin m_ptr = nx; m_mode = 1; m_left = ON_T; end
              end
            end
          end
        end
      end
      if (commit && m_pv) begin m_act = m_pend; m_adp = m_pdp; m_pv = 0; end
      if (fire) begin m_pend = wr_data; m_pdp = wr_dp; m_pv = 1; end
    end
    if (m_mode == 1) begin
      e_scan = ~(8'd1 << m_ptr);
      e_seg  = {~m_adp[m_ptr], gl[m_act[m_ptr*4 +: 4]][6:0]};
    end else begin
      e_scan = 8'hFF;
      e_seg  = 8'hFF;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_scan", scan_out, e_scan);
      chk("model_seg", seg_out, e_seg);
      chk("model_frame_done", frame_done, e_fd);
      chk("model_wr_ready", wr_ready, !m_pv);
    end
  end

  task automatic wait_scan(input logic [7:0] v, input int budget, input string nm);
    int n = 0;
    while (scan_out !== v && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (scan_out !== v) begin
      errors++;
      $display("FAIL %s: timeout, scan_out=%h required %h", nm, scan_out, v);
    end
  endtask

  task automatic wait_fd(input int budget, input string nm, output int cycles);
    cycles = 0;
    @(negedge clk);
    cycles = 1;
    while (frame_done !== 1'b1 && cycles < budget) begin @(negedge clk); cycles++; end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s: timeout waiting frame_done, got %b required 1", nm, frame_done);
    end
  endtask

  initial begin
    int cyc, n_fe, n_fb, n_ff, n_other;

    repeat (3) @(negedge clk);
    chk("reset_scan", scan_out, 8'hFF);
    chk("reset_seg", seg_out, 8'hFF);
    chk("reset_fd", frame_done, 1'b0);
    chk("reset_ready", wr_ready, 1'b1);

    reset = 1'b0; enable = 1'b1; digit_mask = 8'hFF;
    wait_scan(8'hFE, 4, "first_digit");
    chk("first_seg", seg_out, 8'hC0);
    chk("first_ready", wr_ready, 1'b1);

    // Back-to-back writes during frame 1.
    wr_data = 32'h76543210; wr_dp = 8'h00; wr_valid = 1'b1;
    @(negedge clk);
    chk("wr1_ready_low", wr_ready, 1'b0);
    wr_data = 32'h89ABCDEF; wr_dp = 8'h01;
    cyc = 0;
    while (!wr_ready && cyc < 200) begin @(negedge clk); cyc++; end
    chk("wr2_frame_end", frame_done, 1'b1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr2_accepted", wr_ready, 1'b0);
    wait_scan(8'hFD, 20, "frame2_digit1");
    chk("frame2_digit1_seg", seg_out, 8'hF9);
    wait_fd(120, "frame2_end", cyc);
    wait_fd(120, "frame3_end", cyc);
    chk("frame_period_ff", cyc, 96);
    // Frame 4 shows the second write: digit 0 = F with its dp lit.
    chk("frame4_digit0_seg", seg_out, 8'h0E);

    // Two-digit mask.
    digit_mask = 8'b0000_0101;
    wait_fd(120, "mask_settle", cyc);
    wait_fd(60, "mask_frame", cyc);
    chk("frame_period_0101", cyc, 24);
    n_fe = 0; n_fb = 0; n_ff = 0; n_other = 0;
    for (int i = 0; i < 24; i++) begin
      case (scan_out)
        8'hFE: n_fe++;
        8'hFB: n_fb++;
        8'hFF: n_ff++;
        default: n_other++;
      endcase
      @(negedge clk);
    end
    chk("mask_fe_cycles", n_fe, 8);
    chk("mask_fb_cycles", n_fb, 8);
    chk("mask_ff_cycles", n_ff, 8);
    chk("mask_other_cycles", n_other, 0);

    // Enable drop during digit 3.
    digit_mask = 8'hFF;
    wait_scan(8'hF7, 200, "reach_digit3");
    enable = 1'b0;
    @(negedge clk);
    chk("disable_scan", scan_out, 8'hFF);
    chk("disable_seg", seg_out, 8'hFF);
    enable = 1'b1;
    wait_scan(8'hFE, 4, "reenable_digit0");

    // Reset during a gap with a write pending.
    wait_fd(200, "pre_reset_frame", cyc);
    wr_data = 32'h11111111; wr_dp = 8'hFF; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("pend_before_reset", wr_ready, 1'b0);
    wait_scan(8'hFD, 30, "reach_digit1");
    wait_scan(8'hFF, 12, "reach_blank");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_scan", scan_out, 8'hFF);
    chk("midreset_seg", seg_out, 8'hFF);
    chk("midreset_ready", wr_ready, 1'b1);
    wait_scan(8'hFE, 4, "after_reset_digit0");
    chk("after_reset_seg", seg_out, 8'hC0);

    // Randomized phase, checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 399) == 0);
      if (enable) enable = ($urandom_range(0, 79) != 0);
      else        enable = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 149) == 0)
        digit_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      wr_valid = ($urandom_range(0, 7) == 0);
      wr_data  = $urandom;
      wr_dp    = 8'($urandom);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
